// File: rtl/pre_if_fetch_queue_pkg.sv
// Shared types and constants for the pre-IF fetch queue and its RVC expander.
package pre_if_pkg;

  localparam int PRE_IF_XLEN = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [1:0] RVC_QUAD_MASK = 2'b11;

  // addr width is the package default; the top narrows/extends on the way in/out
  typedef struct packed {
    logic [PRE_IF_XLEN-1:0] addr;
    logic [31:0]            data;
  } fetch_entry_t;

endpackage

// File: rtl/pre_if_fetch_queue_expander.sv
// RV32C -> RV32I expander; unsupported or reserved encodings expand to 0.
module c_instruction_expander
  import pre_if_pkg::*;
(
  input  logic [15:0] c_inst,
  output logic [31:0] inst
);

  logic [15:0] c;
  logic [4:0]  rd, rs2, rd_p, rs1_p;
  logic [6:0]  f7;
  logic [2:0]  f3;

  assign c     = c_inst;
  assign rd    = c[11:7];
  assign rs2   = c[6:2];
  assign rd_p  = {2'b01, c[4:2]};
  assign rs1_p = {2'b01, c[9:7]};

  always_comb begin
    inst = '0;
    f7   = (c[6:5] == 2'b00) ? 7'h20 : 7'h00;
    case (c[6:5])
      2'b00:   f3 = 3'b000;
      2'b01:   f3 = 3'b100;
      2'b10:   f3 = 3'b110;
      default: f3 = 3'b111;
    endcase
    if (c[1:0] != RVC_QUAD_MASK) begin
      case ({c[15:13], c[1:0]})
        5'b000_00: if (c[12:5] != '0)
                     inst = {2'b0, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000, rd_p, 7'h13};
        5'b010_00: inst = {5'b0, c[5], c[12:10], c[6], 2'b00, rs1_p, 3'b010, rd_p, 7'h03};
        5'b110_00: inst = {5'b0, c[5], c[12], rd_p, rs1_p, 3'b010, c[11:10], c[6], 2'b00, 7'h23};
        // c.nop and the rd=0 hints collapse onto the canonical NOP
        5'b000_01: inst = (rd == 5'd0) ? NOP : {{7{c[12]}}, c[6:2], rd, 3'b000, rd, 7'h13};
        5'b001_01,
        5'b101_01: inst = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], c[12],
                           {8{c[12]}}, (c[15] ? 5'd0 : 5'd1), 7'h6f};
        5'b010_01: inst = {{7{c[12]}}, c[6:2], 5'd0, 3'b000, rd, 7'h13};
        5'b011_01: if (rd == 5'd2)
                     inst = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0, 5'd2, 3'b000, 5'd2, 7'h13};
                   else
                     inst = {{15{c[12]}}, c[6:2], rd, 7'h37};
        5'b100_01: case (c[11:10])
                     2'b00:   inst = {7'h00, c[6:2], rs1_p, 3'b101, rs1_p, 7'h13};
                     2'b01:   inst = {7'h20, c[6:2], rs1_p, 3'b101, rs1_p, 7'h13};
                     2'b10:   inst = {{7{c[12]}}, c[6:2], rs1_p, 3'b111, rs1_p, 7'h13};
                     default: if (!c[12]) inst = {f7, rd_p, rs1_p, f3, rs1_p, 7'h33};
                   endcase
        5'b110_01,
        5'b111_01: inst = {c[12], {3{c[12]}}, c[6:5], c[2], 5'd0, rs1_p, 2'b00, c[13],
                           c[11:10], c[4:3], c[12], 7'h63};
        5'b000_10: inst = {7'h00, c[6:2], rd, 3'b001, rd, 7'h13};
        5'b010_10: inst = {4'b0, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, rd, 7'h03};
        5'b100_10: begin
          if (!c[12])
            inst = (rs2 == 5'd0) ? {12'b0, rd, 3'b000, 5'd0, 7'h67}
                                 : {7'h00, rs2, 5'd0, 3'b000, rd, 7'h33};
          else if (rs2 == 5'd0)
            inst = (rd == 5'd0) ? 32'h0010_0073 : {12'b0, rd, 3'b000, 5'd1, 7'h67};
          else
            inst = {7'h00, rs2, rd, 3'b000, rd, 7'h33};
        end
        5'b110_10: inst = {4'b0, c[8:7], c[12], c[6:2], 5'd2, 3'b010, c[11:9], 2'b00, 7'h23};
        default:   inst = '0;
      endcase
    end
  end

endmodule

// File: rtl/pre_if_fetch_queue.sv
// Pre-IF fetch queue: buffers icache words, presents one instruction per cycle to the IFU.
// Define PRE_IF_RVC_EN to enable 16-bit realignment and RVC expansion.
module pre_if_fetch_queue
  import pre_if_pkg::*;
#(
  parameter int XLEN  = PRE_IF_XLEN,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic [XLEN-1:0]            redirect_pc_i,
  input  logic                       icache_valid_i,
  input  logic [XLEN-1:0]            icache_addr_i,
  input  logic [31:0]                icache_data_i,
  output logic                       icache_ready_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [31:0]                out_inst_o,
  output logic [XLEN-1:0]            out_pc_o,
  output logic                       out_is_rvc_o,
  output logic                       stall_if_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t    mem [DEPTH];
  fetch_entry_t    cur;
  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   count;
  logic            full, push, fire, pop, rvc, avail;
  logic [31:0]     inst_raw;
  logic [XLEN-1:0] pc_raw;
  logic            unused_bits;

  assign cur  = mem[head];
  assign full = (count == CW'(DEPTH));
  assign push = icache_valid_i && !full;
  assign fire = avail && out_ready_i;

`ifdef PRE_IF_RVC_EN
  logic        hoff;
  logic [15:0] half, nxt_lo;
  logic [31:0] exp_inst;

  assign nxt_lo   = mem[head + PW'(1)].data[15:0];
  assign half     = hoff ? cur.data[31:16] : cur.data[15:0];
  assign rvc      = (half[1:0] != RVC_QUAD_MASK);
  // a 32-bit instruction starting in the upper half needs the next word too
  assign avail    = (count != '0) && (rvc || !hoff || count > CW'(1));
  assign inst_raw = rvc ? exp_inst : hoff ? {nxt_lo, cur.data[31:16]} : cur.data;
  assign pc_raw   = XLEN'(cur.addr) + (hoff ? XLEN'(2) : XLEN'(0));
  assign pop      = fire && (hoff || !rvc);
  assign unused_bits = ^{redirect_pc_i[XLEN-1:2], redirect_pc_i[0]};

  c_instruction_expander u_exp (
    .c_inst (half),
    .inst   (exp_inst)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               hoff <= 1'b0;
    else if (flush_i)      hoff <= redirect_pc_i[1];
    else if (fire && rvc)  hoff <= !hoff;
  end
`else
  assign rvc      = 1'b0;
  assign avail    = (count != '0);
  assign inst_raw = cur.data;
  assign pc_raw   = XLEN'(cur.addr);
  assign pop      = fire;
  assign unused_bits = ^redirect_pc_i;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush_i)
      mem[tail] <= '{addr: PRE_IF_XLEN'(icache_addr_i), data: icache_data_i};
  end

  assign icache_ready_o = !full;
  assign out_valid_o    = avail;
  assign stall_if_o     = !avail;
  assign out_inst_o     = avail ? inst_raw : '0;
  assign out_pc_o       = avail ? pc_raw : '0;
  assign out_is_rvc_o   = avail && rvc;
  assign count_o        = count;

endmodule

// File: tb/tb_pre_if_fetch_queue.sv
// Self-checking bench for pre_if_fetch_queue: directed cases plus a randomized halfword-stream model.
module tb_pre_if_fetch_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);
`ifdef PRE_IF_RVC_EN
  localparam bit RVC = 1'b1;
`else
  localparam bit RVC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic          ic_valid = 1'b0;
  logic [31:0]   ic_addr = '0;
  logic [31:0]   ic_data = '0;
  logic          ic_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_inst;
  logic [31:0]   out_pc;
  logic          out_rvc;
  logic          stall;
  logic [CW-1:0] count;

  int total = 0;
  int bad   = 0;

  pre_if_fetch_queue #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush_i        (flush),
    .redirect_pc_i  (redirect_pc),
    .icache_valid_i (ic_valid),
    .icache_addr_i  (ic_addr),
    .icache_data_i  (ic_data),
    .icache_ready_o (ic_ready),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_inst_o     (out_inst),
    .out_pc_o       (out_pc),
    .out_is_rvc_o   (out_rvc),
    .stall_if_o     (stall),
    .count_o        (count)
  );

  always #5 clk = ~clk;

  // known RVC encodings and their hand-derived RV32I expansions
  logic [15:0] ct_c [6] = '{16'h4501, 16'h0001, 16'h0505, 16'h852e, 16'h8082, 16'h4108};
  logic [31:0] ct_e [6] = '{32'h0000_0513, 32'h0000_0013, 32'h0015_0513,
                            32'h00b0_0533, 32'h0000_8067, 32'h0005_2503};

  typedef struct {
    logic [31:0] pc;
    logic [15:0] h;
  } hw_t;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] expand_ref(input logic [15:0] h);
    for (int i = 0; i < 6; i++)
      if (ct_c[i] == h) return ct_e[i];
    return 32'hdead_beef;
  endfunction

  function automatic bit is_c(input logic [15:0] h);
    return RVC && (h[1:0] != 2'b11);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] a, input logic [31:0] d);
    ic_valid = 1'b1;
    ic_addr  = a;
    ic_data  = d;
    tick();
    ic_valid = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] inst,
                           input logic [31:0] pc, input logic c);
    check({tag, "_valid"}, out_valid, v);
    check({tag, "_inst"},  out_inst,  inst);
    check({tag, "_pc"},    out_pc,    pc);
    check({tag, "_rvc"},   out_rvc,   c);
  endtask

  task automatic check_reset(input string tag);
    check_out(tag, 1'b0, 32'h0, 32'h0, 1'b0);
    check({tag, "_stall"}, stall, 1'b1);
    check({tag, "_count"}, count, 0);
    check({tag, "_ready"}, ic_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    hw_t         hq[$];
    logic [31:0] wd[$];
    logic [15:0] hl[$];
    logic [31:0] r, base;
    int          words, idx, cyc, k;
    bit          c0, ev, fire, push;

    // reset state
    #12;
    check_reset("rst");
    rst = 1'b0;
    tick();

    // single 32-bit word
    push_word(32'h8000_0000, 32'h0000_0013);
    check_out("w32", 1'b1, 32'h13, 32'h8000_0000, 1'b0);
    check("w32_count", count, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("w32_pop_count", count, 0);
    check("w32_pop_stall", stall, 1'b1);

`ifdef PRE_IF_RVC_EN
    // two c.li a0,0 in one word
    push_word(32'h8000_0000, 32'h4501_4501);
    check_out("c2a", 1'b1, 32'h513, 32'h8000_0000, 1'b1);
    out_ready = 1'b1;
    tick();
    check_out("c2b", 1'b1, 32'h513, 32'h8000_0002, 1'b1);
    check("c2b_count", count, 1);
    tick();
    out_ready = 1'b0;
    check("c2_pop_count", count, 0);

    // 32-bit instruction straddling a word boundary
    push_word(32'h8000_0000, 32'h0013_4501);
    check_out("st0", 1'b1, 32'h513, 32'h8000_0000, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("st_wait_valid", out_valid, 1'b0);
    check("st_wait_count", count, 1);
    push_word(32'h8000_0004, 32'h4501_0000);
    check_out("st1", 1'b1, 32'h13, 32'h8000_0002, 1'b0);
    out_ready = 1'b1;
    tick();
    check_out("st2", 1'b1, 32'h513, 32'h8000_0006, 1'b1);
    check("st2_count", count, 1);
    tick();
    out_ready = 1'b0;
    check("st_end_count", count, 0);
`endif

    // fill, then full-with-pop (no bypass), then push+pop, then push only
    for (int i = 0; i < 4; i++)
      push_word(32'h8000_1000 + 32'(4*i), 32'h13 | 32'(i << 7));
    check("full_count", count, 4);
    check("full_ready", ic_ready, 1'b0);
    check_out("full_head", 1'b1, 32'h13, 32'h8000_1000, 1'b0);
    ic_valid = 1'b1; ic_addr = 32'h8000_1010; ic_data = 32'h13 | (32'd4 << 7);
    out_ready = 1'b1;
    tick();
    check("full_pop_count", count, 3);
    check("full_pop_pc", out_pc, 32'h8000_1004);
    tick();
    check("pushpop_count", count, 3);
    ic_addr = 32'h8000_1014; ic_data = 32'h13 | (32'd5 << 7);
    out_ready = 1'b0;
    tick();
    check("refill_count", count, 4);
    check_out("refill_head", 1'b1, 32'h113, 32'h8000_1008, 1'b0);

    // flush while full with a push and a pop offered
    ic_addr = 32'h8000_1018; flush = 1'b1; redirect_pc = 32'h8000_0102; out_ready = 1'b1;
    tick();
    flush = 1'b0; ic_valid = 1'b0; out_ready = 1'b0;
    check("flush_count", count, 0);
    check("flush_valid", out_valid, 1'b0);
    check("flush_ready", ic_ready, 1'b1);
    push_word(32'h8000_0100, 32'h4501_0013);
`ifdef PRE_IF_RVC_EN
    check_out("redir", 1'b1, 32'h513, 32'h8000_0102, 1'b1);
`else
    check_out("redir", 1'b1, 32'h4501_0013, 32'h8000_0100, 1'b0);
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("redir_pop_count", count, 0);

    // asynchronous reset mid-stream
    for (int i = 0; i < 3; i++)
      push_word(32'h8000_3000 + 32'(4*i), 32'h13);
    check("mid_count", count, 3);
    #2 rst = 1'b1;
    #1 check_reset("mid_rst");
    #2 rst = 1'b0;
    tick();
    check("mid_after_count", count, 0);

    // randomized stream against a halfword-queue model
    if (RVC) begin
      while (hl.size() < 120) begin
        if ($urandom % 2 == 0) begin
          hl.push_back(ct_c[$urandom % 6]);
        end else begin
          r = $urandom | 32'h3;
          hl.push_back(r[15:0]);
          hl.push_back(r[31:16]);
        end
      end
      if (hl.size() % 2 == 1) hl.push_back(16'h0001);
      for (int i = 0; i < hl.size() / 2; i++)
        wd.push_back({hl[2*i+1], hl[2*i]});
    end else begin
      for (int i = 0; i < 60; i++) wd.push_back($urandom);
    end

    base  = 32'h8000_2000;
    words = 0;
    idx   = 0;
    cyc   = 0;
    while ((idx < wd.size() || hq.size() != 0) && cyc < 3000) begin
      c0 = (hq.size() > 0) && is_c(hq[0].h);
      ev = (hq.size() > 0) && (c0 || hq.size() >= 2);
      check("r_valid", out_valid, ev);
      check("r_count", count, words);
      check("r_ready", ic_ready, words < DEPTH);
      if (ev) begin
        check("r_pc", out_pc, hq[0].pc);
        check("r_inst", out_inst, c0 ? expand_ref(hq[0].h) : {hq[1].h, hq[0].h});
        check("r_rvc", out_rvc, c0);
      end else begin
        check("r_idle_inst", out_inst, 32'h0);
      end
      ic_valid  = (idx < wd.size()) && ($urandom % 4 != 0);
      ic_addr   = base + 32'(4*idx);
      ic_data   = (idx < wd.size()) ? wd[idx] : 32'h0;
      out_ready = ($urandom % 3 != 0);
      fire = ev && out_ready;
      push = ic_valid && (words < DEPTH);
      tick();
      cyc++;
      if (fire) begin
        k = c0 ? 1 : 2;
        for (int j = 0; j < k; j++) begin
          if (hq[0].pc[1]) words--;
          hq.delete(0);
        end
      end
      if (push) begin
        hq.push_back('{pc: ic_addr,        h: ic_data[15:0]});
        hq.push_back('{pc: ic_addr + 32'd2, h: ic_data[31:16]});
        words++;
        idx++;
      end
    end
    ic_valid  = 1'b0;
    out_ready = 1'b0;
    check("r_drained", (idx == wd.size()) && (hq.size() == 0), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
